// File: rtl/udma_rx_width_conv.sv
// Receive-path width converter: packs PHY_W-bit beats into DST_W-bit uDMA words.
// It drops leading offset bytes, can byte-swap each beat and zero-fills the tail of the final word.
module udma_rx_width_conv #(
  parameter int PHY_W      = 16,
  parameter int DST_W      = 32,
  parameter int TRANS_SIZE = 16,
  parameter int OFFS_W     = (DST_W / 8 > 1) ? $clog2(DST_W / 8) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  cfg_start_i,
  input  logic [TRANS_SIZE-1:0] cfg_len_i,
  input  logic [OFFS_W-1:0]     cfg_offset_i,
  input  logic                  cfg_swap_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [PHY_W-1:0]      src_data_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [DST_W-1:0]      dst_data_o,
  output logic                  dst_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PB    = PHY_W / 8;
  localparam int DB    = DST_W / 8;
  localparam int ACC_B = DB + PB;
  localparam int CNT_W = $clog2(ACC_B + 1);
  localparam int CW    = TRANS_SIZE + 1;

  localparam logic [CNT_W-1:0] DB_C    = CNT_W'(DB);
  localparam logic [CW-1:0]    PB_C    = CW'(PB);
  localparam logic [CW-1:0]    PB_M1_C = CW'(PB - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [PHY_W-1:0] swap_bytes(input logic [PHY_W-1:0] d);
    logic [PHY_W-1:0] r;
    for (int i = 0; i < PB; i++) begin
      r[8*i +: 8] = d[8*(PB-1-i) +: 8];
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [CW-1:0]          in_beats_q, in_beats_d;
  logic [CW-1:0]          acc_rem_q, acc_rem_d;
  logic [CW-1:0]          out_rem_q, out_rem_d;
  logic [OFFS_W-1:0]      skip_q, skip_d;
  logic                   swap_q, swap_d;
  logic [ACC_B-1:0][7:0]  acc_q, acc_d;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic                   dvalid_q, dvalid_d;
  logic [DST_W-1:0]       ddata_q, ddata_d;
  logic                   dlast_q, dlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   src_ready_s;
  logic                   accept_s;
  logic [PHY_W-1:0]       beat_s;
  logic [ACC_B-1:0][7:0]  acc_app_s;
  logic [ACC_B-1:0][7:0]  acc_shift_s;
  logic [CNT_W-1:0]       cnt_app_s;
  logic [OFFS_W-1:0]      skip_app_s;
  logic [CW-1:0]          rem_app_s;
  logic                   load_ok_s;
  logic                   has_word_s;
  logic                   load_s;
  logic [CNT_W-1:0]       load_n_s;
  logic [DST_W-1:0]       word_s;

  assign src_ready_s = (state_q == ST_RUN) && (in_beats_q != '0) && (acc_cnt_q < DB_C);
  assign accept_s    = src_ready_s && src_valid_i;
  assign beat_s      = swap_q ? swap_bytes(src_data_i) : src_data_i;

  // Append the accepted beat: skip leading offset bytes, drop trailing padding bytes.
  always_comb begin
    acc_app_s  = acc_q;
    cnt_app_s  = acc_cnt_q;
    skip_app_s = skip_q;
    rem_app_s  = acc_rem_q;
    if (accept_s) begin
      for (int i = 0; i < PB; i++) begin
        if (skip_app_s != '0) begin
          skip_app_s = skip_app_s - OFFS_W'(1);
        end else if (rem_app_s != '0) begin
          acc_app_s[cnt_app_s] = beat_s[8*i +: 8];
          cnt_app_s            = cnt_app_s + CNT_W'(1);
          rem_app_s            = rem_app_s - CW'(1);
        end else begin
          cnt_app_s = cnt_app_s;
        end
      end
    end else begin
      acc_app_s = acc_q;
    end
  end

  // Output-register load: a full word, or the final partial word once all payload is in.
  // Loading from the post-append view lets a word become valid the cycle after its last beat.
  always_comb begin
    load_ok_s   = !dvalid_q || dst_ready_i;
    has_word_s  = (cnt_app_s >= DB_C) || ((cnt_app_s != '0) && (rem_app_s == '0));
    load_s      = load_ok_s && has_word_s && ((state_q == ST_RUN) || (state_q == ST_FLUSH));
    load_n_s    = (cnt_app_s >= DB_C) ? DB_C : cnt_app_s;
    for (int j = 0; j < DB; j++) begin
      word_s[8*j +: 8] = (CNT_W'(j) < load_n_s) ? acc_app_s[j] : 8'h00;
    end
    acc_shift_s = acc_app_s >> {load_n_s, 3'b000};
  end

  // Next-state logic for the FSM, counters, accumulator and output register.
  always_comb begin
    state_d    = state_q;
    in_beats_d = accept_s ? (in_beats_q - CW'(1)) : in_beats_q;
    skip_d     = skip_app_s;
    acc_rem_d  = rem_app_s;
    swap_d     = swap_q;
    acc_d      = load_s ? acc_shift_s : acc_app_s;
    acc_cnt_d  = load_s ? (cnt_app_s - load_n_s) : cnt_app_s;
    out_rem_d  = load_s ? (out_rem_q - CW'(load_n_s)) : out_rem_q;
    dvalid_d   = dvalid_q;
    ddata_d    = ddata_q;
    dlast_d    = dlast_q;

    if (clr_i) begin
      state_d    = ST_IDLE;
      in_beats_d = '0;
      skip_d     = '0;
      acc_rem_d  = '0;
      out_rem_d  = '0;
      swap_d     = 1'b0;
      acc_d      = '0;
      acc_cnt_d  = '0;
      dvalid_d   = 1'b0;
      ddata_d    = '0;
      dlast_d    = 1'b0;
    end else begin
      if (load_s) begin
        dvalid_d = 1'b1;
        ddata_d  = word_s;
        dlast_d  = (CW'(load_n_s) == out_rem_q);
      end else if (dst_ready_i) begin
        dvalid_d = 1'b0;
      end else begin
        dvalid_d = dvalid_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_start_i) begin
            in_beats_d = (CW'(cfg_offset_i) + CW'(cfg_len_i) + PB_M1_C) / PB_C;
            skip_d     = cfg_offset_i;
            acc_rem_d  = CW'(cfg_len_i);
            out_rem_d  = CW'(cfg_len_i);
            swap_d     = cfg_swap_i;
            state_d    = (cfg_len_i == '0) ? ST_DONE : ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s && (in_beats_q == CW'(1))) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (dvalid_q && dst_ready_i && dlast_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d = (state_q == ST_DONE) && !clr_i;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      in_beats_q <= '0;
      skip_q     <= '0;
      acc_rem_q  <= '0;
      out_rem_q  <= '0;
      swap_q     <= 1'b0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      dvalid_q   <= 1'b0;
      ddata_q    <= '0;
      dlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_beats_q <= in_beats_d;
      skip_q     <= skip_d;
      acc_rem_q  <= acc_rem_d;
      out_rem_q  <= out_rem_d;
      swap_q     <= swap_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      dvalid_q   <= dvalid_d;
      ddata_q    <= ddata_d;
      dlast_q    <= dlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign src_ready_o = src_ready_s;
  assign dst_valid_o = dvalid_q;
  assign dst_data_o  = ddata_q;
  assign dst_last_o  = dlast_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_udma_rx_width_conv.sv
// Scoreboard bench for udma_rx_width_conv: 16->32 instance plus an 8->64 instance.
module tb_udma_rx_width_conv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  initial begin
    forever #5 clk = ~clk;
  end

  // 16 -> 32 instance
  logic        a_clr = 1'b0, a_start = 1'b0, a_swap = 1'b0, a_sv = 1'b0, a_dr = 1'b0;
  logic [15:0] a_len = 16'h0, a_sd = 16'h0;
  logic [1:0]  a_off = 2'd0;
  logic        a_sr, a_dv, a_dl, a_busy, a_done;
  logic [31:0] a_dd;

  udma_rx_width_conv #(.PHY_W(16), .DST_W(32), .TRANS_SIZE(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .cfg_start_i(a_start), .cfg_len_i(a_len),
    .cfg_offset_i(a_off), .cfg_swap_i(a_swap), .src_valid_i(a_sv), .src_ready_o(a_sr),
    .src_data_i(a_sd), .dst_valid_o(a_dv), .dst_ready_i(a_dr), .dst_data_o(a_dd),
    .dst_last_o(a_dl), .busy_o(a_busy), .done_o(a_done)
  );

  // 8 -> 64 instance
  logic        b_clr = 1'b0, b_start = 1'b0, b_swap = 1'b0, b_sv = 1'b0, b_dr = 1'b0;
  logic [15:0] b_len = 16'h0;
  logic [7:0]  b_sd = 8'h0;
  logic [2:0]  b_off = 3'd0;
  logic        b_sr, b_dv, b_dl, b_busy, b_done;
  logic [63:0] b_dd;

  udma_rx_width_conv #(.PHY_W(8), .DST_W(64), .TRANS_SIZE(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .cfg_start_i(b_start), .cfg_len_i(b_len),
    .cfg_offset_i(b_off), .cfg_swap_i(b_swap), .src_valid_i(b_sv), .src_ready_o(b_sr),
    .src_data_i(b_sd), .dst_valid_o(b_dv), .dst_ready_i(b_dr), .dst_data_o(b_dd),
    .dst_last_o(b_dl), .busy_o(b_busy), .done_o(b_done)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] beat_q[$];
  logic [31:0] exp_w[$], got_w[$];
  bit          exp_l[$], got_l[$];
  int          n_acc, n_done, stall_acc;
  bit          tmo, stall_err, stall_rdy;

  // Reference packer: byte stream after optional swap, drop offset, keep len, little-endian words.
  function automatic void build_exp(input int len, input int offs, input bit swp);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int          n;
    for (int i = 0; i < beat_q.size(); i++) begin
      logic [15:0] bt;
      bt = beat_q[i];
      if (swp) begin
        bytes.push_back(bt[15:8]); bytes.push_back(bt[7:0]);
      end else begin
        bytes.push_back(bt[7:0]); bytes.push_back(bt[15:8]);
      end
    end
    w = 32'h0; n = 0;
    for (int i = offs; i < offs + len; i++) begin
      w[8*n +: 8] = bytes[i];
      n++;
      if (n == 4) begin
        exp_w.push_back(w); exp_l.push_back(i == offs + len - 1);
        w = 32'h0; n = 0;
      end
    end
    if (n > 0) begin
      exp_w.push_back(w); exp_l.push_back(1'b1);
    end
  endfunction

  // Drives one transfer on instance A from beat_q and records accepted beats and output words.
  task automatic xfer_a(input int len, input int offs, input bit swp, input int stall_cyc, input bit rnd);
    int idx, cyc, post;
    logic pv, pr, pl;
    logic [31:0] pd;
    idx = 0; cyc = 0; post = 0; n_acc = 0; n_done = 0; tmo = 1'b0;
    stall_err = 1'b0; stall_rdy = 1'b1; stall_acc = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'h0;
    got_w.delete(); got_l.delete();
    @(posedge clk); #1;
    a_len = 16'(len); a_off = 2'(offs); a_swap = swp; a_start = 1'b1;
    while (post < 3 && !tmo) begin
      @(posedge clk); #1;
      a_start = 1'b0;
      a_sv = (idx < beat_q.size());
      a_sd = (idx < beat_q.size()) ? beat_q[idx] : 16'h0;
      a_dr = (cyc < stall_cyc) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (pv && !pr && (!a_dv || a_dd !== pd || a_dl !== pl)) stall_err = 1'b1;
      if (a_sv && a_sr) begin idx++; n_acc++; end
      if (cyc == stall_cyc - 1) begin stall_rdy = a_sr; stall_acc = n_acc; end
      if (a_dv && a_dr) begin got_w.push_back(a_dd); got_l.push_back(a_dl); end
      if (a_done) n_done++;
      if (n_done > 0) post++;
      pv = a_dv; pr = a_dr; pd = a_dd; pl = a_dl;
      cyc++;
      if (cyc > 400) tmo = 1'b1;
    end
    a_sv = 1'b0; a_dr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({a_sr, a_dv, a_dl, a_busy, a_done} !== 5'b0) begin
      errors++; $display("FAIL reset_a_ctrl got %b exp 00000", {a_sr, a_dv, a_dl, a_busy, a_done});
    end
    checks++;
    if (a_dd !== 32'h0) begin errors++; $display("FAIL reset_a_data got %h exp 0", a_dd); end
    checks++;
    if ({b_sr, b_dv, b_dl, b_busy, b_done} !== 5'b0 || b_dd !== 64'h0) begin
      errors++; $display("FAIL reset_b got %b/%h exp 0", {b_sr, b_dv, b_dl, b_busy, b_done}, b_dd);
    end
  endtask

  task automatic test_aligned();
    beat_q = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
    exp_w = '{32'h44332211, 32'h88776655};
    exp_l = '{1'b0, 1'b1};
    xfer_a(8, 0, 1'b0, 0, 1'b0);
    checks++; if (tmo) begin errors++; $display("FAIL aligned_timeout got 1 exp 0"); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL aligned_done got %0d exp 1", n_done); end
    checks++; if (n_acc != 4) begin errors++; $display("FAIL aligned_beats got %0d exp 4", n_acc); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL aligned_busy got %b exp 0", a_busy); end
    while (exp_w.size() > 0) begin
      logic [31:0] ew; bit el;
      ew = exp_w.pop_front(); el = exp_l.pop_front();
      checks++;
      if (got_w.size() == 0) begin errors++; $display("FAIL aligned_word missing exp %h", ew); end
      else begin
        logic [31:0] gw; bit gl;
        gw = got_w.pop_front(); gl = got_l.pop_front();
        if (gw !== ew || gl !== el) begin
          errors++; $display("FAIL aligned_word got %h/%0b exp %h/%0b", gw, gl, ew, el);
        end
      end
    end
    checks++; if (got_w.size() != 0) begin errors++; $display("FAIL aligned_extra got %0d exp 0", got_w.size()); end
  endtask

  task automatic test_offset();
    beat_q = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
    exp_w = '{32'h44332211, 32'h00000055};
    exp_l = '{1'b0, 1'b1};
    xfer_a(5, 1, 1'b0, 0, 1'b0);
    checks++; if (tmo || n_done != 1) begin errors++; $display("FAIL offset_done got %0d/%0b exp 1/0", n_done, tmo); end
    checks++; if (n_acc != 3) begin errors++; $display("FAIL offset_beats got %0d exp 3", n_acc); end
    while (exp_w.size() > 0) begin
      logic [31:0] ew; bit el;
      ew = exp_w.pop_front(); el = exp_l.pop_front();
      checks++;
      if (got_w.size() == 0) begin errors++; $display("FAIL offset_word missing exp %h", ew); end
      else begin
        logic [31:0] gw; bit gl;
        gw = got_w.pop_front(); gl = got_l.pop_front();
        if (gw !== ew || gl !== el) begin
          errors++; $display("FAIL offset_word got %h/%0b exp %h/%0b", gw, gl, ew, el);
        end
      end
    end
    checks++; if (got_w.size() != 0) begin errors++; $display("FAIL offset_extra got %0d exp 0", got_w.size()); end
  endtask

  task automatic test_swap();
    for (int s = 1; s >= 0; s--) begin
      logic [31:0] ew;
      ew = (s == 1) ? 32'h04030201 : 32'h03040102;
      beat_q = '{16'h0102, 16'h0304};
      xfer_a(4, 0, 1'(s), 0, 1'b0);
      checks++;
      if (tmo || n_done != 1 || n_acc != 2) begin
        errors++; $display("FAIL swap%0d_ctrl got done %0d beats %0d tmo %0b exp 1 2 0", s, n_done, n_acc, tmo);
      end
      checks++;
      if (got_w.size() != 1 || got_w[0] !== ew || got_l[0] !== 1'b1) begin
        errors++; $display("FAIL swap%0d_word got n=%0d %h exp n=1 %h last", s, got_w.size(),
                           (got_w.size() > 0) ? got_w[0] : 32'h0, ew);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int run = 0; run < 2; run++) begin
      int len, offs; bit swp;
      len = (run == 0) ? 16 : 13; offs = (run == 0) ? 0 : 3; swp = (run == 1);
      beat_q.delete(); exp_w.delete(); exp_l.delete();
      for (int i = 0; i < 8; i++) beat_q.push_back(16'($urandom));
      build_exp(len, offs, swp);
      xfer_a(len, offs, swp, (run == 0) ? 8 : 0, 1'b1);
      checks++; if (tmo || n_done != 1) begin errors++; $display("FAIL bp%0d_done got %0d/%0b exp 1/0", run, n_done, tmo); end
      checks++; if (n_acc != 8) begin errors++; $display("FAIL bp%0d_beats got %0d exp 8", run, n_acc); end
      checks++; if (stall_err) begin errors++; $display("FAIL bp%0d_stable got unstable exp stable", run); end
      if (run == 0) begin
        checks++; if (stall_acc != 4) begin errors++; $display("FAIL bp_full_beats got %0d exp 4", stall_acc); end
        checks++; if (stall_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", stall_rdy); end
      end
      while (exp_w.size() > 0) begin
        logic [31:0] ew; bit el;
        ew = exp_w.pop_front(); el = exp_l.pop_front();
        checks++;
        if (got_w.size() == 0) begin errors++; $display("FAIL bp%0d_word missing exp %h", run, ew); end
        else begin
          logic [31:0] gw; bit gl;
          gw = got_w.pop_front(); gl = got_l.pop_front();
          if (gw !== ew || gl !== el) begin
            errors++; $display("FAIL bp%0d_word got %h/%0b exp %h/%0b", run, gw, gl, ew, el);
          end
        end
      end
      checks++; if (got_w.size() != 0) begin errors++; $display("FAIL bp%0d_extra got %0d exp 0", run, got_w.size()); end
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] seq;
    bit bad;
    seq = 4'b0; bad = 1'b0;
    @(posedge clk); #1;
    a_len = 16'h0; a_off = 2'd0; a_swap = 1'b0; a_start = 1'b1; a_sv = 1'b1; a_sd = 16'hBEEF; a_dr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq = {seq[2:0], a_done};
      bad = bad | a_sr | a_dv;
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    a_sv = 1'b0; a_dr = 1'b0;
    checks++; if (seq !== 4'b0010) begin errors++; $display("FAIL zero_done_seq got %b exp 0010", seq); end
    checks++; if (bad) begin errors++; $display("FAIL zero_activity got 1 exp 0"); end
  endtask

  task automatic test_abort();
    int idx, cyc;
    bit pre_v, pre_b, done_seen;
    idx = 0; cyc = 0; done_seen = 1'b0;
    @(posedge clk); #1;
    a_len = 16'd32; a_off = 2'd0; a_swap = 1'b0; a_start = 1'b1; a_dr = 1'b0;
    while (idx < 3 && cyc < 50) begin
      @(posedge clk); #1;
      a_start = 1'b0; a_sv = 1'b1; a_sd = 16'h1000 + 16'(idx);
      @(negedge clk);
      if (a_sv && a_sr) idx++;
      cyc++;
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL abort_beats got %0d exp 3", idx); end
    @(posedge clk); #1;
    a_sv = 1'b0; a_clr = 1'b1;
    @(negedge clk);
    pre_v = a_dv; pre_b = a_busy;
    checks++; if ({pre_v, pre_b} !== 2'b11) begin errors++; $display("FAIL abort_pre got %b exp 11", {pre_v, pre_b}); end
    @(posedge clk); #1;
    a_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_dv, a_busy, a_sr} !== 3'b000 || a_dd !== 32'h0) begin
      errors++; $display("FAIL abort_clear got %b/%h exp 000/0", {a_dv, a_busy, a_sr}, a_dd);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      done_seen = done_seen | a_done;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL abort_done got 1 exp 0"); end
    beat_q = '{16'h0102, 16'h0304};
    xfer_a(4, 0, 1'b1, 0, 1'b0);
    checks++;
    if (n_done != 1 || got_w.size() != 1 || got_w[0] !== 32'h04030201) begin
      errors++; $display("FAIL abort_recover got done %0d words %0d exp 1 1", n_done, got_w.size());
    end
  endtask

  task automatic test_param2();
    int idx, cyc, nd, post;
    logic [63:0] gw[$];
    bit gl[$];
    idx = 0; cyc = 0; nd = 0; post = 0;
    @(posedge clk); #1;
    b_len = 16'd10; b_off = 3'd3; b_start = 1'b1; b_dr = 1'b1;
    while (post < 3 && cyc < 200) begin
      @(posedge clk); #1;
      b_start = 1'b0; b_sv = (idx < 13); b_sd = 8'(idx);
      @(negedge clk);
      if (b_sv && b_sr) idx++;
      if (b_dv && b_dr) begin gw.push_back(b_dd); gl.push_back(b_dl); end
      if (b_done) nd++;
      if (nd > 0) post++;
      cyc++;
    end
    b_sv = 1'b0; b_dr = 1'b0;
    checks++; if (idx != 13) begin errors++; $display("FAIL p2_beats got %0d exp 13", idx); end
    checks++; if (nd != 1) begin errors++; $display("FAIL p2_done got %0d exp 1", nd); end
    checks++; if (gw.size() != 2) begin errors++; $display("FAIL p2_count got %0d exp 2", gw.size()); end
    if (gw.size() == 2) begin
      checks++;
      if (gw[0] !== 64'h0A09080706050403 || gl[0] !== 1'b0) begin
        errors++; $display("FAIL p2_word0 got %h/%0b exp 0a09080706050403/0", gw[0], gl[0]);
      end
      checks++;
      if (gw[1] !== 64'h0000000000000C0B || gl[1] !== 1'b1) begin
        errors++; $display("FAIL p2_word1 got %h/%0b exp 0000000000000c0b/1", gw[1], gl[1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #12;
    test_reset();
    #10;
    rst_n = 1'b1;
    test_aligned();
    test_offset();
    test_swap();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_param2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
